// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters.
// Grants are registered and burst-limited; ack/w_en/wdata follow req/full combinationally.
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                       wclk,
    input  logic                       wrst_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*DATA_WIDTH-1:0] wdata_in,
    input  logic                       full,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            ack,
    output logic                       w_en,
    output logic [DATA_WIDTH-1:0]      wdata
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state;
    logic [IW-1:0]  own;
    logic [IW-1:0]  last;
    logic [IW-1:0]  base;
    logic [IW-1:0]  win;
    logic [IW-1:0]  idx;
    logic           found;
    logic [CW-1:0]  cnt;
    logic           take;
    logic           burst_end;
    logic           release_now;

    // On release, last becomes own, so searching from own+1 covers both
    // the idle and handoff cases. A dropped owner has req[own]=0 already,
    // so no explicit mask is needed; a burst-ended owner is found last.
    always_comb begin
        base  = (state == GRANT) ? own : last;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IW'((int'(base) + i) % NREQ);
            if (req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign ack  = full ? '0 : (gnt & req);
    assign w_en = |ack;

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) wdata = wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign take        = ack[own];
    assign burst_end   = take && (cnt == CW'(MAX_BURST - 1));
    assign release_now = (state == GRANT) && (!req[own] || burst_end);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state <= IDLE;
            gnt   <= '0;
            own   <= '0;
            cnt   <= '0;
            last  <= IW'(NREQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        gnt   <= NREQ'(1) << win;
                        own   <= win;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        last <= own;
                        cnt  <= '0;
                        if (found) begin
                            gnt <= NREQ'(1) << win;
                            own <= win;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end else if (take) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the async FIFO write domain. Shares the single FIFO write port (`w_en`/`wdata`) among `NREQ` requesters, honouring the registered `full` flag from the write-pointer logic and limiting each grant to a bounded burst so no requester starves. Sits entirely in the `wclk` domain, directly in front of the FIFO write side.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `DATA_WIDTH`, 8: FIFO word width.
- `MAX_BURST`, 4: maximum accepted words per grant (≥1).

- `wclk` in 1: write-domain clock.
- `wrst_n` in 1: asynchronous active-low reset.
- `req` in `NREQ`: per-requester level request; data valid while high.
- `wdata_in` in `NREQ*DATA_WIDTH`: requester i's word on bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `full` in 1: FIFO full flag, registered, from the write-pointer logic.
- `gnt` out `NREQ`: registered one-hot grant, or zero.
- `ack` out `NREQ`: combinational; `gnt & req` when `full`=0, else 0. Word accepted this cycle.
- `w_en` out 1: combinational FIFO write enable, `|ack`.
- `wdata` out `DATA_WIDTH`: combinational; word of the granted requester, 0 when `gnt`=0.

## Operation
- State: `IDLE` (`gnt`=0) and `GRANT` (one-hot `gnt`, owner index `own`), burst counter `cnt` (0..`MAX_BURST`), last-owner pointer `last`.
- Arbitration: search `req` starting at `last+1` mod `NREQ`, wrapping. The first set bit wins. The previous owner wins only if it is the sole requester.
- `IDLE`: if `|req`, register the winner into `gnt`, set `own`, clear `cnt`, and go to `GRANT`. Otherwise stay.
- `GRANT`: each cycle with `ack[own]` increments `cnt`.
- Release from `GRANT` occurs when either:
  - (a) `req[own]`=0, or
  - (b) an accepted word makes `cnt` reach `MAX_BURST`.
- On release:
  - `last` ← `own`.
  - Arbitrate the same cycle using the current `req`, with `req[own]` masked in case (a) and unmasked in case (b).
  - If there is a winner, load the new `gnt`, clear `cnt`, and stay in `GRANT`. This is a back-to-back handoff with no idle cycle.
  - Otherwise go to `IDLE` with `gnt`=0.
- `full`=1 blocks acceptance. `cnt` holds and the grant is held; `full` alone never releases a grant. A `req` drop while full still releases.
- Requester contract:
  - Hold `wdata_in` stable while `req` is high.
  - A word is consumed only in a cycle where its `ack` is high.
  - Deasserting `req` withdraws the request without consuming a word.
- `w_en` is never high while `full`=1. The write-pointer logic's own `!full` gating is redundant but harmless.
- Arithmetic: `cnt` is `$clog2(MAX_BURST+1)` bits and never exceeds `MAX_BURST`. The pointer wraps modulo `NREQ`, including non-power-of-2 values.

## Timing
- Reset (async, `wrst_n`=0):
  - State `IDLE`, `gnt`=0, `cnt`=0, `last`=`NREQ-1` (requester 0 has first priority).
  - Hence `ack`=0, `w_en`=0, `wdata`=0 immediately, independent of `wclk`.
- Grant latency: `req` sampled high at edge k → `gnt` high after edge k. First possible `w_en` is in cycle k+1 (between edges k and k+1).
- Sustained throughput: one word per cycle while granted `req`=1 and `full`=0, including across burst handoffs.
- Burst end: the word that makes `cnt`=`MAX_BURST` is accepted in cycle t. The new `gnt` is visible in cycle t+1.
- `ack`, `w_en` and `wdata` respond combinationally to `req`/`full` within the cycle. There is no registered path from `req` to `w_en` beyond `gnt`.
- Reset mid-burst: outputs clear immediately. After reset release, arbitration restarts from requester 0 and partial burst counts are discarded.

## Test plan
- **Reset then single requester:** `req`=0001, `full`=0 held.
  - After reset, all outputs are 0.
  - `gnt`=0001 one cycle after `req`.
  - 4 words are written, then `gnt` is re-granted to 0001 with `cnt` cleared and no `w_en` gap.
- **All requesting:** `req`=1111, `full`=0.
  - `gnt` sequence is 0001×4 words, 0010×4, 0100×4, 1000×4, 0001.
  - `w_en` is continuously 1 after the first grant.
  - `wdata` matches the owner's word each cycle.
- **Full mid-burst:** owner 0 has 2 words accepted, then `full`=1 for 5 cycles.
  - `w_en`=`ack`=0 and `gnt`=0001 is held.
  - After `full`=0, exactly 2 more words are written, then handoff to the next requester.
- **Early drop:** `req`=1110, owner 1 drops `req` after 1 word.
  - Next cycle `gnt`=0100.
  - Requester 1 receives no `ack` after the drop.
- **Async reset mid-burst:** assert `wrst_n`=0 between edges.
  - `gnt`, `w_en`, `wdata` go to 0 before the next edge.
  - After release with `req`=1010, the first grant is 0010.
- **Corner configuration:** `NREQ`=3, `MAX_BURST`=1, `req`=111.
  - Grants rotate 001→010→100→001 each cycle.
  - The pointer wraps correctly at the non-power-of-2 `NREQ`.
